// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word RAM plus an MMIO block with LED, switch, a
// free-running timer and a UART TX FIFO. Read data is registered (1-cycle latency).
module data_sram_responder #(
   parameter int RAM_AW     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [7:0]  switch,
   output logic [15:0] led,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [15:0] OFF_LED    = 16'hF000;
   localparam logic [15:0] OFF_SWITCH = 16'hF010;
   localparam logic [15:0] OFF_TIMER  = 16'hF020;
   localparam logic [15:0] OFF_UDATA  = 16'hF030;
   localparam logic [15:0] OFF_USTAT  = 16'hF034;

   logic [31:0]       r_ram [2**RAM_AW];
   logic [31:0]       r_ram_q;
   logic [31:0]       r_mmio_q;
   logic              r_rd_ram;
   logic [15:0]       r_led;
   logic [31:0]       r_timer;
   logic [7:0]        r_fifo [FIFO_DEPTH];
   logic [PW-1:0]     r_rptr;
   logic [PW-1:0]     r_wptr;
   logic [CW-1:0]     r_count;
   logic              r_ovf;

   logic              w_is_mmio;
   logic [15:0]       w_off;
   logic [RAM_AW-1:0] w_ram_idx;
   logic              w_led_wr;
   logic              w_timer_wr;
   logic              w_stat_wr;
   logic              w_push_req;
   logic              w_push_ok;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [31:0]       w_status;
   logic [31:0]       w_mmio_rdata;

   assign w_is_mmio  = (data_sram_addr[31:16] == 16'hbfaf);
   assign w_off      = data_sram_addr[15:0];
   assign w_ram_idx  = data_sram_addr[RAM_AW+1:2];

   assign w_led_wr   = data_sram_we && w_is_mmio && (w_off == OFF_LED);
   assign w_timer_wr = data_sram_we && w_is_mmio && (w_off == OFF_TIMER);
   assign w_stat_wr  = data_sram_we && w_is_mmio && (w_off == OFF_USTAT);
   assign w_push_req = data_sram_we && w_is_mmio && (w_off == OFF_UDATA);

   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_pop      = !w_empty && uart_tx_ready;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign w_push_ok  = w_push_req && (!w_full || w_pop);

   assign uart_tx_valid   = !w_empty;
   assign uart_tx_data    = r_fifo[r_rptr];
   assign led             = r_led;
   assign data_sram_rdata = r_rd_ram ? r_ram_q : r_mmio_q;

   always_comb begin
      w_status           = '0;
      w_status[0]        = w_full;
      w_status[1]        = w_empty;
      w_status[2]        = r_ovf;
      w_status[7 +: CW]  = r_count;
   end

   always_comb begin
      w_mmio_rdata = '0;
      case (w_off)
         OFF_LED:    w_mmio_rdata = {16'b0, r_led};
         OFF_SWITCH: w_mmio_rdata = {24'b0, switch};
         OFF_TIMER:  w_mmio_rdata = r_timer;
         OFF_USTAT:  w_mmio_rdata = w_status;
         default:    w_mmio_rdata = '0;
      endcase
   end

   // RAM is kept out of reset so its contents survive a reset.
   always_ff @(posedge clk) begin
      if (data_sram_we && !w_is_mmio)
         r_ram[w_ram_idx] <= data_sram_wdata;
      r_ram_q <= r_ram[w_ram_idx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ram <= 1'b0;
         r_mmio_q <= '0;
      end else begin
         r_rd_ram <= !w_is_mmio;
         r_mmio_q <= w_is_mmio ? w_mmio_rdata : 32'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_led   <= '0;
         r_timer <= '0;
      end else begin
         if (w_led_wr)
            r_led <= data_sram_wdata[15:0];
         if (w_timer_wr)
            r_timer <= data_sram_wdata;
         else
            r_timer <= r_timer + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_fifo[i] <= '0;
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_fifo[r_wptr] <= data_sram_wdata[7:0];
            r_wptr         <= r_wptr + PW'(1);
         end
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         if (w_push_ok && !w_pop)
            r_count <= r_count + CW'(1);
         else if (!w_push_ok && w_pop)
            r_count <= r_count - CW'(1);
         if (w_push_req && !w_push_ok)
            r_ovf <= 1'b1;
         else if (w_stat_wr)
            r_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: vector table for RAM/MMIO decode plus
// hand-written timer, FIFO and reset sequences; read data scored via a queue.
module tb_data_sram_responder;

   logic        clk;
   logic        reset;
   logic        data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [7:0]  switch;
   logic [15:0] led;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        chk;
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  sw;
      logic        chk;
      logic [31:0] exp_rdata;
      logic [15:0] exp_led;
   } vec_t;
   vec_t vecs[19];

   localparam logic [31:0] A_LED   = 32'hbfaff000;
   localparam logic [31:0] A_SW    = 32'hbfaff010;
   localparam logic [31:0] A_TIMER = 32'hbfaff020;
   localparam logic [31:0] A_UDATA = 32'hbfaff030;
   localparam logic [31:0] A_USTAT = 32'hbfaff034;

   data_sram_responder #(.RAM_AW(10), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .data_sram_we   (data_sram_we),
      .data_sram_addr (data_sram_addr),
      .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata),
      .switch         (switch),
      .led            (led),
      .uart_tx_data   (uart_tx_data),
      .uart_tx_valid  (uart_tx_valid),
      .uart_tx_ready  (uart_tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // One bus cycle: drive, push expectation, clock, pop and compare.
   task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic chk, input logic [31:0] exp, input string nm);
      sb_t e;
      data_sram_we    = we;
      data_sram_addr  = a;
      data_sram_wdata = d;
      sb.push_back('{chk, exp, nm});
      @(posedge clk);
      #1;
      data_sram_we = 1'b0;
      if (sb.size() == 0) begin
         check32({nm, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         if (e.chk) check32(e.name, data_sram_rdata, e.exp);
      end
   endtask

   task automatic check_tx(input string nm, input logic exp_valid, input logic [7:0] exp_data);
      check32({nm, "_valid"}, {31'd0, uart_tx_valid}, {31'd0, exp_valid});
      if (exp_valid) check32({nm, "_data"}, {24'd0, uart_tx_data}, {24'd0, exp_data});
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h1c000010, 32'h12345678, 8'h00, 1'b0, 32'h0,        16'h0};
      vecs[1]  = '{1'b0, 32'h1c000010, 32'h0,        8'h00, 1'b1, 32'h12345678, 16'h0};
      vecs[2]  = '{1'b1, 32'h1c000010, 32'hAAAA5555, 8'h00, 1'b1, 32'h12345678, 16'h0};
      vecs[3]  = '{1'b0, 32'h1c000010, 32'h0,        8'h00, 1'b1, 32'hAAAA5555, 16'h0};
      vecs[4]  = '{1'b0, 32'h00000010, 32'h0,        8'h00, 1'b1, 32'hAAAA5555, 16'h0};
      vecs[5]  = '{1'b1, 32'h1c000ffc, 32'hCAFEF00D, 8'h00, 1'b0, 32'h0,        16'h0};
      vecs[6]  = '{1'b0, 32'h1c000ffc, 32'h0,        8'h00, 1'b1, 32'hCAFEF00D, 16'h0};
      vecs[7]  = '{1'b1, 32'hbfae0010, 32'h11112222, 8'h00, 1'b1, 32'hAAAA5555, 16'h0};
      vecs[8]  = '{1'b0, 32'h1c000010, 32'h0,        8'h00, 1'b1, 32'h11112222, 16'h0};
      vecs[9]  = '{1'b1, A_LED,        32'hDEADBEEF, 8'h00, 1'b1, 32'h0,        16'hBEEF};
      vecs[10] = '{1'b0, A_LED,        32'h0,        8'h00, 1'b1, 32'h0000BEEF, 16'hBEEF};
      vecs[11] = '{1'b0, A_SW,         32'h0,        8'hA5, 1'b1, 32'h000000A5, 16'hBEEF};
      vecs[12] = '{1'b1, A_SW,         32'hFFFFFFFF, 8'hA5, 1'b1, 32'h000000A5, 16'hBEEF};
      vecs[13] = '{1'b0, A_SW,         32'h0,        8'h3C, 1'b1, 32'h0000003C, 16'hBEEF};
      vecs[14] = '{1'b1, 32'hbfaff040, 32'h00001234, 8'h00, 1'b1, 32'h0,        16'hBEEF};
      vecs[15] = '{1'b0, 32'hbfaff040, 32'h0,        8'h00, 1'b1, 32'h0,        16'hBEEF};
      vecs[16] = '{1'b0, A_UDATA,      32'h0,        8'h00, 1'b1, 32'h0,        16'hBEEF};
      vecs[17] = '{1'b0, A_USTAT,      32'h0,        8'h00, 1'b1, 32'h00000002, 16'hBEEF};
      vecs[18] = '{1'b0, A_LED,        32'h0,        8'h00, 1'b1, 32'h0000BEEF, 16'hBEEF};

      reset = 1'b0; data_sram_we = 1'b0; data_sram_addr = '0; data_sram_wdata = '0;
      switch = '0; uart_tx_ready = 1'b0;
      #1 reset = 1'b1;
      #1;
      check32("rst_rdata", data_sram_rdata, 32'h0);
      check32("rst_led", {16'd0, led}, 32'h0);
      check_tx("rst_tx", 1'b0, 8'h00);
      check32("rst_txdata", {24'd0, uart_tx_data}, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      cyc(1'b0, A_TIMER, 32'h0, 1'b1, 32'h0, "timer_first");
      cyc(1'b0, A_TIMER, 32'h0, 1'b1, 32'h1, "timer_second");

      for (int i = 0; i < 19; i++) begin
         switch = vecs[i].sw;
         cyc(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp_rdata,
             $sformatf("vec%0d_rdata", i));
         check32($sformatf("vec%0d_led", i), {16'd0, led}, {16'd0, vecs[i].exp_led});
      end

      cyc(1'b1, A_TIMER, 32'hFFFFFFFE, 1'b0, 32'h0, "timer_load");
      cyc(1'b0, A_TIMER, 32'h0, 1'b1, 32'hFFFFFFFE, "timer_fe");
      cyc(1'b0, A_TIMER, 32'h0, 1'b1, 32'hFFFFFFFF, "timer_ff");
      cyc(1'b0, A_TIMER, 32'h0, 1'b1, 32'h00000000, "timer_wrap");

      uart_tx_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         cyc(1'b1, A_UDATA, 32'h41 + i, 1'b1, 32'h0, $sformatf("push%0d", i));
      check_tx("fill_head", 1'b1, 8'h41);
      cyc(1'b0, A_USTAT, 32'h0, 1'b1, 32'h00000205, "stat_full_ovf");
      uart_tx_ready = 1'b1;
      begin
         logic [31:0] exp_st [4];
         exp_st[0] = 32'h205; exp_st[1] = 32'h184; exp_st[2] = 32'h104; exp_st[3] = 32'h084;
         for (int i = 0; i < 4; i++) begin
            check_tx($sformatf("drain%0d", i), 1'b1, 8'(8'h41 + i));
            cyc(1'b0, A_USTAT, 32'h0, 1'b1, exp_st[i], $sformatf("drain_stat%0d", i));
         end
      end
      check_tx("drain_done", 1'b0, 8'h00);
      cyc(1'b1, A_USTAT, 32'h0, 1'b1, 32'h00000006, "stat_clr_wr");
      cyc(1'b0, A_USTAT, 32'h0, 1'b1, 32'h00000002, "stat_cleared");

      uart_tx_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         cyc(1'b1, A_UDATA, 32'h51 + i, 1'b0, 32'h0, "push_full");
      check_tx("pp_head", 1'b1, 8'h51);
      uart_tx_ready = 1'b1;
      cyc(1'b1, A_UDATA, 32'h5A, 1'b1, 32'h0, "push_pop_full");
      uart_tx_ready = 1'b0;
      check_tx("pp_after", 1'b1, 8'h52);
      cyc(1'b0, A_USTAT, 32'h0, 1'b1, 32'h00000201, "stat_pp");
      uart_tx_ready = 1'b1;
      begin
         logic [7:0] exp_b [4];
         exp_b[0] = 8'h52; exp_b[1] = 8'h53; exp_b[2] = 8'h54; exp_b[3] = 8'h5A;
         for (int i = 0; i < 4; i++) begin
            check_tx($sformatf("pp_drain%0d", i), 1'b1, exp_b[i]);
            cyc(1'b0, 32'h1c000100, 32'h0, 1'b0, 32'h0, "pp_idle");
         end
      end
      check_tx("pp_done", 1'b0, 8'h00);

      cyc(1'b1, A_UDATA, 32'h77, 1'b0, 32'h0, "push_empty_ready");
      check_tx("empty_pp", 1'b1, 8'h77);
      cyc(1'b0, A_USTAT, 32'h0, 1'b1, 32'h00000080, "stat_one");
      check_tx("empty_pp_done", 1'b0, 8'h00);

      uart_tx_ready = 1'b0;
      cyc(1'b1, 32'h1c000020, 32'h0BADC0DE, 1'b0, 32'h0, "ram_pre_rst");
      for (int i = 0; i < 3; i++)
         cyc(1'b1, A_UDATA, 32'h61 + i, 1'b0, 32'h0, "push_pre_rst");
      check_tx("pre_rst", 1'b1, 8'h61);
      uart_tx_ready = 1'b1;
      #2 reset = 1'b1;
      #1;
      check_tx("mid_rst", 1'b0, 8'h00);
      check32("mid_rst_txdata", {24'd0, uart_tx_data}, 32'h0);
      check32("mid_rst_rdata", data_sram_rdata, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      uart_tx_ready = 1'b0;
      cyc(1'b0, A_USTAT, 32'h0, 1'b1, 32'h00000002, "post_rst_stat");
      cyc(1'b0, 32'h1c000020, 32'h0, 1'b1, 32'h0BADC0DE, "post_rst_ram");
      check32("post_rst_led", {16'd0, led}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder side of the core's data SRAM port: services the `data_sram_we/addr/wdata/rdata` requests issued every cycle by the core. It contains:
- a word-addressed local RAM;
- a small memory-mapped register block: LED, switch, free-running timer, and a UART transmit FIFO with a valid/ready drain port.

It sits between the core top and the board I/O, and replaces a plain SRAM on the data side.

## Interface
Parameters:
- RAM_AW, 10, RAM word-address width (2^RAM_AW words of 32 bits)
- FIFO_DEPTH, 4, UART TX FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- data_sram_we  in  1  write strobe, full 32-bit word
- data_sram_addr  in  32  byte address; bits [1:0] ignored
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  registered read data
- switch  in  8  board switches, sampled directly
- led  out  16  LED register
- uart_tx_data  out  8  FIFO head byte
- uart_tx_valid  out  1  FIFO non-empty
- uart_tx_ready  in  1  consumer accepts head this cycle

## Operation
Address decode, evaluated every cycle:
- MMIO when addr[31:16]==16'hbfaf.
- Otherwise RAM, word index addr[RAM_AW+1:2]; upper bits are aliased (ignored).

MMIO offsets (addr[15:0]):
- 0xF000 LED: RW. Reads return {16'b0, led}. Writes load wdata[15:0].
- 0xF010 SWITCH: RO. Reads return {24'b0, switch}. Writes are ignored.
- 0xF020 TIMER: RW, 32 bits.
  - Increments by 1 every cycle and wraps 0xFFFFFFFF→0.
  - A write loads wdata; the write takes priority over the increment on that edge.
- 0xF030 UART_DATA: WO.
  - A write pushes wdata[7:0].
  - Reads return 0.
- 0xF034 UART_STATUS: RW.
  - Read value: bit0 full, bit1 empty, bit2 overflow (sticky), bits[7+:n] entry count; all other bits 0.
  - Any write clears overflow.
- Any other MMIO offset: reads return 0, writes are ignored.

RAM:
- A write updates the addressed word at the edge.
- Contents are not reset.
- Read-during-write to the same word returns the old data (read-first).

UART FIFO:
- Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH, plus a count of 0..FIFO_DEPTH.
- Pop when uart_tx_valid && uart_tx_ready.
- Push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle (full with simultaneous push and pop: count is unchanged and the data is kept).
- A rejected push sets overflow and leaves the FIFO unchanged.
- Push and pop on empty: push is accepted and no pop occurs (valid was 0).
- uart_tx_data = entry at the read pointer; it holds stable while valid && !ready.

## Timing
- Read latency is exactly 1 cycle. rdata in cycle n+1 reflects the address presented in cycle n, using state before the cycle-n edge update:
  - TIMER read returns the pre-increment value;
  - STATUS read returns pre-push/pop flags.
- rdata updates every cycle. On a write cycle it returns the old content of the addressed location.
- Write effects are visible to a read issued in the next cycle.
- Reset (async assert, synchronous to clk when deasserted) sets:
  - data_sram_rdata=0, led=0, timer=0;
  - FIFO empty, uart_tx_valid=0, uart_tx_data=0 (the head entry is cleared), overflow=0.
- Reset mid-operation discards FIFO contents. The RAM keeps its contents.
- The first timer increment occurs at the first edge after reset deasserts.
- No combinational path from data_sram_* to data_sram_rdata. uart_tx_valid and uart_tx_data depend only on registered state.

## Test plan
- RAM: write 0x12345678 to 0x1c000010, read it next cycle → rdata=0x12345678. Same-cycle read+write of 0x1c000010 with 0xAAAA5555 → rdata=0x12345678, then 0xAAAA5555 on the following read.
- LED/SWITCH: write 0xDEADBEEF to 0xbfaff000 → led=0xBEEF, read returns 0x0000BEEF. Switch=0xA5 → read 0xbfaff010 returns 0x000000A5. A write to 0xbfaff010 is ignored.
- Timer: write 0xFFFFFFFE at edge k → reads in subsequent cycles return 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000. After reset, the first read returns 0.
- FIFO fill/overflow: ready=0, push 0x41..0x45 (5 writes) → status=full, overflow=1, count=4. Drain with ready=1 → bytes 0x41..0x44 in order, valid falls after the 4th. Write to status → overflow=0.
- Full simultaneous push+pop: FIFO full, ready=1, push 0x5A in the same cycle → no overflow, count stays 4, 0x5A is emitted last.
- Async reset asserted mid-drain with 3 entries queued → uart_tx_valid=0 immediately. After release, status reads empty=1, count=0, and RAM data written before reset reads back unchanged.
